mem_rd_arb: RTL and testbench
=============================

MEM_RD_ARB -- requirements
Module: mem_rd_arb

Interface
REQ-001 Parameter WIDTH, default 32: data width, equal to the WIDTH of the attached parametric memory.
REQ-002 Parameter DEPTH, default 512: memory depth in words; AW = $clog2(DEPTH).
REQ-003 Parameter N_REQ, default 4: number of read requesters, 2..16; IDW = $clog2(N_REQ).
REQ-004 clkB  input  1  read-port clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N_REQ  per-requester read request.
REQ-007 req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_addr  input  N_REQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumer accept.
REQ-011 rsp_id  output  IDW  requester index of the response.
REQ-012 rsp_data  output  WIDTH  read data.
REQ-013 rsp_err  output  1  the response is for an out-of-range address.
REQ-014 mem_enB  output  1  memory read enable, driven to the memory enB.
REQ-015 mem_addrB  output  AW  memory read address, driven to the memory addrB.
REQ-016 mem_doutB  input  WIDTH  memory read data, valid the cycle after mem_enB.

Function
REQ-017 Requester i is accepted in cycle t when req_valid[i]=1, i is the round-robin winner, and credit is available; req_ready[i] is combinational in the same cycle.
REQ-018 Round-robin: the search starts at pointer p; after an accept of i, p becomes (i+1) mod N_REQ; p is unchanged in cycles with no accept.
REQ-019 Credit is available when inflight + fifo_count - pop < 2; pop = rsp_valid & rsp_ready in the same cycle.
REQ-020 On an in-range accept (addr < DEPTH): mem_enB=1 and mem_addrB=addr in cycle t, combinationally; mem_enB=0 in all other cycles.
REQ-021 Out-of-range accept (addr >= DEPTH): mem_enB stays 0; the response is rsp_err=1, rsp_data=0, with the same latency and ordering.
REQ-022 In cycle t+1, mem_doutB (or zero for an error) plus id and err are pushed into the 2-entry response FIFO; rsp_valid is first seen in cycle t+2.
REQ-023 Responses return in accept order; sustained throughput is 1 per cycle while rsp_ready=1.
REQ-024 While rsp_ready=0, at most 2 reads are outstanding and the FIFO never overflows; a held rsp_valid keeps rsp_id, rsp_data and rsp_err stable.
REQ-025 A push and a pop in the same cycle on a full FIFO is legal and leaves the occupancy unchanged.

Reset
REQ-026 While rst=1: req_ready=0, mem_enB=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
REQ-027 Reset sets p=0, inflight=0 and empties the FIFO; in-flight reads are discarded and their data is never presented after rst is released.
REQ-028 Requests can be accepted in the first cycle after rst deasserts.

Configuration
REQ-029 Macro MEM_RD_ARB_STATS_EN, when defined, adds output conflict_cnt[31:0]; it increments each cycle where two or more req_valid bits are high and no request is accepted, saturates at 0xFFFFFFFF, and resets to 0.
REQ-030 Without MEM_RD_ARB_STATS_EN the port and counter are absent; all other behaviour is identical.

Structure
REQ-031 Package mem_rd_arb_pkg holds the response entry typedef (data, id, err), the FIFO depth constant (2) and the saturating counter maximum.
REQ-032 Sub-module mem_rd_rsp_fifo: a 2-entry synchronous FIFO with push/pop/full/empty and registered outputs, instantiated once.

Verification
REQ-033 Requesters 0..3 all valid continuously, rsp_ready=1: accept order 0,1,2,3,0,...; one response per cycle; rsp_id matches the accept order.
REQ-034 Single requester, addr=5, memory preloaded word5=0xDEADBEEF: mem_enB=1 in cycle t; rsp_valid in t+2 with rsp_data=0xDEADBEEF, rsp_id=0, rsp_err=0.
REQ-035 DEPTH=500, request addr=510: mem_enB stays 0; the response has rsp_err=1 and rsp_data=0 in t+2.
REQ-036 rsp_ready=0 with continuous requests: exactly 2 accepts, then req_ready=0; raising rsp_ready drains both in order with no loss.
REQ-037 rst asserted the cycle after an accept: no rsp_valid appears after release; the next accept goes to requester 0.
REQ-038 With MEM_RD_ARB_STATS_EN, 3 requesters valid and rsp_ready=0 for 10 cycles after the FIFO fills: conflict_cnt=10.

Source files
------------

// File: rtl/mem_rd_arb_pkg.sv
// Shared types and constants for the mem_rd_arb read arbiter and its response FIFO.
package mem_rd_arb_pkg;

    localparam int RSP_DATA_W     = 64;  // widest supported WIDTH
    localparam int RSP_ID_W       = 4;   // covers up to 16 requesters
    localparam int RSP_FIFO_DEPTH = 2;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] data;
        logic [RSP_ID_W-1:0]   id;
        logic                  err;
    } rsp_entry_t;

    // True when at least two bits of the vector are set.
    function automatic logic two_or_more(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/mem_rd_rsp_fifo.sv
// Two-entry synchronous response FIFO; head, full, empty and count all come straight from registers.
module mem_rd_rsp_fifo
    import mem_rd_arb_pkg::*;
(
    input  logic       clkB,
    input  logic       rst,
    input  logic       push,
    input  rsp_entry_t push_entry,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [1:0] count,
    output rsp_entry_t head
);

    localparam int PW = $clog2(RSP_FIFO_DEPTH);
    localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);

    rsp_entry_t     mem_r [RSP_FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           full_s;
    logic           empty_s;
    logic           do_push_s;
    logic           do_pop_s;

    assign full_s    = (count_r == CW'(RSP_FIFO_DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign do_pop_s  = pop & ~empty_s;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push_s = push & (~full_s | do_pop_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clkB) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r <= (wr_ptr_r == PW'(RSP_FIFO_DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PW'(RSP_FIFO_DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/mem_rd_arb.sv
// Round-robin read arbiter for one memory read port with a 2-deep, credit-protected response FIFO.
// Optional MEM_RD_ARB_STATS_EN adds conflict_cnt, a saturating count of stalled multi-request cycles.
module mem_rd_arb
    import mem_rd_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int N_REQ = 4,
    localparam int AW  = $clog2(DEPTH),
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic                 clkB,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*AW-1:0]  req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_err,
`ifdef MEM_RD_ARB_STATS_EN
    output logic [31:0]          conflict_cnt,
`endif
    output logic                 mem_enB,
    output logic [AW-1:0]        mem_addrB,
    input  logic [WIDTH-1:0]     mem_doutB
);

    logic [IDW-1:0] p_r;
    logic           inflight_r;
    logic [IDW-1:0] id_d_r;
    logic           err_d_r;

    logic           win_found_s;
    logic [IDW-1:0] win_idx_s;
    logic [AW-1:0]  win_addr_s;
    logic           in_range_s;
    logic           credit_s;
    logic           accept_s;
    logic           pop_s;
    logic [2:0]     occupancy_s;
    rsp_entry_t     push_entry_s;
    rsp_entry_t     head_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [1:0]     fifo_count_s;
    logic           unused_s;

    // Round-robin search starting at the pointer.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDW{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found_s && req_valid[(int'(p_r) + k) % N_REQ]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDW'((int'(p_r) + k) % N_REQ);
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end

    assign win_addr_s = req_addr[int'(win_idx_s)*AW +: AW];
    assign in_range_s = ({{(32-AW){1'b0}}, win_addr_s} < 32'(DEPTH));

    // Reads in the memory pipeline plus FIFO entries never exceed the FIFO depth.
    assign pop_s       = rsp_valid & rsp_ready;
    assign occupancy_s = 3'(inflight_r) + 3'(fifo_count_s) - 3'(pop_s);
    assign credit_s    = (occupancy_s < 3'(RSP_FIFO_DEPTH));
    assign accept_s    = win_found_s & credit_s & ~rst;

    // One-hot accept towards the winning requester.
    always_comb begin
        req_ready            = {N_REQ{1'b0}};
        req_ready[win_idx_s] = accept_s;
    end

    assign mem_enB   = accept_s & in_range_s;
    assign mem_addrB = win_addr_s;

    // Pointer advance and the one-cycle memory latency stage.
    always_ff @(posedge clkB) begin
        if (rst) begin
            p_r        <= {IDW{1'b0}};
            inflight_r <= 1'b0;
            id_d_r     <= {IDW{1'b0}};
            err_d_r    <= 1'b0;
        end else begin
            inflight_r <= accept_s;
            id_d_r     <= win_idx_s;
            err_d_r    <= ~in_range_s;
            if (accept_s) begin
                p_r <= (int'(win_idx_s) == N_REQ - 1) ? {IDW{1'b0}} : win_idx_s + IDW'(1);
            end
        end
    end

    assign push_entry_s.data = err_d_r ? {RSP_DATA_W{1'b0}} : RSP_DATA_W'(mem_doutB);
    assign push_entry_s.id   = RSP_ID_W'(id_d_r);
    assign push_entry_s.err  = err_d_r;

    mem_rd_rsp_fifo u_rsp_fifo (
        .clkB       (clkB),
        .rst        (rst),
        .push       (inflight_r),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s),
        .head       (head_s)
    );

    assign rsp_valid = ~rst & ~fifo_empty_s;
    assign rsp_id    = rsp_valid ? head_s.id[IDW-1:0]     : {IDW{1'b0}};
    assign rsp_data  = rsp_valid ? head_s.data[WIDTH-1:0] : {WIDTH{1'b0}};
    assign rsp_err   = rsp_valid & head_s.err;

    assign unused_s = ^{fifo_full_s, head_s};

`ifdef MEM_RD_ARB_STATS_EN
    logic [31:0] conflict_cnt_r;

    // Saturating count of cycles with competing requests and no accept.
    always_ff @(posedge clkB) begin
        if (rst) begin
            conflict_cnt_r <= 32'd0;
        end else if (two_or_more(16'(req_valid)) && !accept_s && (conflict_cnt_r != CNT_MAX)) begin
            conflict_cnt_r <= conflict_cnt_r + 32'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_mem_rd_arb.sv
// Randomized bench for mem_rd_arb against a queue-based transaction model of accepts and responses.
module tb_mem_rd_arb;

    localparam int WIDTH = 32;
    localparam int DEPTH = 500;
    localparam int N_REQ = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int IDW   = $clog2(N_REQ);

    logic                clkB = 1'b0;
    logic                rst  = 1'b1;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*AW-1:0] req_addr = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [WIDTH-1:0]    rsp_data;
    logic                rsp_err;
    logic                mem_enB;
    logic [AW-1:0]       mem_addrB;
    logic [WIDTH-1:0]    mem_doutB;
`ifdef MEM_RD_ARB_STATS_EN
    logic [31:0]         conflict_cnt;
    longint              exp_conf = 0;
`endif

    mem_rd_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ)) dut (
        .clkB      (clkB),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
`ifdef MEM_RD_ARB_STATS_EN
        .conflict_cnt (conflict_cnt),
`endif
        .mem_enB   (mem_enB),
        .mem_addrB (mem_addrB),
        .mem_doutB (mem_doutB)
    );

    always #5 clkB = ~clkB;

    // Attached memory: one-cycle read latency, garbage on idle cycles.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clkB) begin
        if (mem_enB && (int'(mem_addrB) < DEPTH)) mem_doutB <= mem[mem_addrB];
        else mem_doutB <= $urandom();
    end

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
        logic             err;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   p     = 0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input int mode);
        logic [AW-1:0] a;
        for (int i = 0; i < N_REQ; i++) begin
            if (mode == 4) a = AW'(5);
            else if (mode == 5) a = AW'(510);
            else if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(DEPTH, (1 << AW) - 1));
            else a = AW'($urandom_range(0, DEPTH - 1));
            req_addr[i*AW +: AW] = a;
        end
        case (mode)
            0:       begin req_valid = 4'hF; rsp_ready = 1'b1; end
            1:       begin req_valid = N_REQ'($urandom()); rsp_ready = ($urandom_range(0, 3) != 0); end
            2:       begin req_valid = 4'hF; rsp_ready = 1'b0; end
            3:       begin req_valid = 4'h0; rsp_ready = 1'b1; end
            4, 5:    begin req_valid = 4'b0001; rsp_ready = 1'b1; end
            6:       begin req_valid = 4'b0111; rsp_ready = 1'b0; end
            default: begin req_valid = 4'h0; rsp_ready = 1'b0; end
        endcase
    endtask

    task automatic model_check();
        logic             exp_valid, pop, credit, found, accept, inr;
        int               win;
        logic [AW-1:0]    a;
        logic [N_REQ-1:0] exp_ready;
        exp_t             e;
        if (rst) begin
            check_val("rst_req_ready", req_ready, 0);
            check_val("rst_mem_enB", mem_enB, 0);
            check_val("rst_rsp_valid", rsp_valid, 0);
            check_val("rst_rsp_id", rsp_id, 0);
            check_val("rst_rsp_data", rsp_data, 0);
            check_val("rst_rsp_err", rsp_err, 0);
            q.delete();
            p = 0;
`ifdef MEM_RD_ARB_STATS_EN
            exp_conf = 0;
`endif
        end else begin
            exp_valid = (q.size() > 0) && (q[0].cyc <= cyc - 2);
            pop       = exp_valid && rsp_ready;
            credit    = (q.size() - (pop ? 1 : 0)) < 2;
            found     = 1'b0;
            win       = 0;
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req_valid[(p + k) % N_REQ]) begin
                    found = 1'b1;
                    win   = (p + k) % N_REQ;
                end
            end
            accept    = found && credit;
            exp_ready = '0;
            if (accept) exp_ready[win] = 1'b1;
            a   = req_addr[win*AW +: AW];
            inr = int'(a) < DEPTH;
            check_val("req_ready", req_ready, exp_ready);
            check_val("mem_enB", mem_enB, accept && inr);
            if (accept && inr) check_val("mem_addrB", mem_addrB, a);
            check_val("rsp_valid", rsp_valid, exp_valid);
            if (exp_valid) begin
                check_val("rsp_id", rsp_id, q[0].id);
                check_val("rsp_data", rsp_data, q[0].data);
                check_val("rsp_err", rsp_err, q[0].err);
            end
`ifdef MEM_RD_ARB_STATS_EN
            check_val("conflict_cnt", conflict_cnt, exp_conf);
            if (($countones(req_valid) >= 2) && !accept && exp_conf < 64'hFFFF_FFFF) exp_conf++;
`endif
            if (pop) void'(q.pop_front());
            if (accept) begin
                e.id   = win;
                e.err  = !inr;
                e.data = inr ? mem[a] : '0;
                e.cyc  = cyc;
                q.push_back(e);
                p = (win + 1) % N_REQ;
            end
        end
        cyc++;
    endtask

    // rst_mode: 0 low, 1 high, 2 occasional random pulse
    task automatic run(input int mode, input int n, input int rst_mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clkB);
            #1;
            rst = (rst_mode == 1) || ((rst_mode == 2) && ($urandom_range(0, 199) == 0));
            drive(mode);
            @(negedge clkB);
            model_check();
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        mem[5] = 32'hDEAD_BEEF;
        run(3, 4, 1);
        run(4, 6, 0);
        run(5, 6, 0);
        run(3, 3, 0);
        run(0, 40, 0);
        run(2, 10, 0);
        run(3, 6, 0);
        run(6, 14, 0);
        run(3, 4, 0);
        run(0, 1, 0);
        run(0, 1, 1);
        run(0, 8, 0);
        run(1, 2000, 2);
        run(2, 12, 0);
        run(1, 300, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
